// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types for the front-end redirect controller
package ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        SLEEP,
        WAKE
    } wfi_state_e;

    // Listed in priority order, highest first
    typedef enum logic [1:0] {
        SRC_TRAP,
        SRC_BJ,
        SRC_WFI
    } redir_src_e;

    localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/redirect_slot.sv
// rtl/redirect_slot.sv - single valid/ready holding register for the redirect target
module redirect_slot
    import ctrl_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] pc_out
);

    // The target stays frozen while valid is high; load wins over completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            pc_out <= '0;
        end else if (load) begin
            valid  <= 1'b1;
            pc_out <= pc_in;
        end else if (valid && ready) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/redirect_ctrl.sv
// rtl/redirect_ctrl.sv - prioritized redirect toward fetch plus WFI sequencer (optional WFI_TIMEOUT_EN)
module redirect_ctrl
    import ctrl_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int WFI_TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic [XLEN-1:0] pc,
    input  logic            bj_en,
    input  logic [XLEN-1:0] bj_pc,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            wfi_op,
    input  logic            irq_pending,
    input  logic            fetch_ready,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_pc,
    output logic            flush,
    output logic            halt_fetch,
    output logic            sleeping
);

    wfi_state_e      state, state_next;
    redir_src_e      src;
    logic            accept;
    logic            take;
    logic            wfi_take;
    logic            load;
    logic [XLEN-1:0] load_pc;
    logic [XLEN-1:0] wake_pc;
    logic            tmo_hit;

    // Events are only looked at while running with an empty slot
    assign accept = !stall && !redir_valid && (state == RUN);

    always_comb begin
        take = 1'b0;
        src  = SRC_TRAP;
        if (accept) begin
            if (trap_en) begin
                take = 1'b1;
                src  = SRC_TRAP;
            end else if (bj_en) begin
                take = 1'b1;
                src  = SRC_BJ;
            end else if (wfi_op) begin
                take = 1'b1;
                src  = SRC_WFI;
            end
        end
    end

    assign wfi_take = take && (src == SRC_WFI);
    assign load     = (take && (src != SRC_WFI)) || (state == WAKE);

    always_comb begin
        load_pc = wake_pc;
        if (state == RUN) begin
            load_pc = (src == SRC_TRAP) ? trap_pc : bj_pc;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (wfi_take) state_next = SLEEP;
            SLEEP:   if (irq_pending || tmo_hit) state_next = WAKE;
            WAKE:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            wake_pc    <= '0;
            flush      <= 1'b0;
            halt_fetch <= 1'b0;
            sleeping   <= 1'b0;
        end else begin
            state      <= state_next;
            if (wfi_take) begin
                wake_pc <= pc + XLEN'(INSN_BYTES);
            end
            // Tracks the slot's next valid, plus the one-cycle kill on sleep entry
            flush      <= load || (redir_valid && !fetch_ready) || wfi_take;
            halt_fetch <= (state_next != RUN);
            sleeping   <= (state_next == SLEEP);
        end
    end

`ifdef WFI_TIMEOUT_EN
    localparam int TMO_W = $clog2(WFI_TIMEOUT + 1);

    logic [TMO_W-1:0] wfi_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wfi_cnt <= '0;
        end else if (wfi_take) begin
            wfi_cnt <= '0;
        end else if (state == SLEEP) begin
            wfi_cnt <= wfi_cnt + TMO_W'(1);
        end
    end

    assign tmo_hit = (state == SLEEP) && (wfi_cnt == TMO_W'(WFI_TIMEOUT - 1));
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = (WFI_TIMEOUT != 0);
    assign tmo_hit        = 1'b0;
`endif

    redirect_slot #(
        .WIDTH (XLEN)
    ) u_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .pc_in  (load_pc),
        .ready  (fetch_ready),
        .valid  (redir_valid),
        .pc_out (redir_pc)
    );

endmodule

// File: tb/tb_redirect_ctrl.sv
// tb/tb_redirect_ctrl.sv - self-checking bench for redirect_ctrl (timeout sequence under WFI_TIMEOUT_EN)
module tb_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [63:0] pc;
    logic        bj_en;
    logic [63:0] bj_pc;
    logic        trap_en;
    logic [63:0] trap_pc;
    logic        wfi_op;
    logic        irq_pending;
    logic        fetch_ready;
    logic        redir_valid;
    logic [63:0] redir_pc;
    logic        flush;
    logic        halt_fetch;
    logic        sleeping;

    always #5 clk = ~clk;

    redirect_ctrl #(
        .XLEN        (64),
        .WFI_TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .pc          (pc),
        .bj_en       (bj_en),
        .bj_pc       (bj_pc),
        .trap_en     (trap_en),
        .trap_pc     (trap_pc),
        .wfi_op      (wfi_op),
        .irq_pending (irq_pending),
        .fetch_ready (fetch_ready),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .flush       (flush),
        .halt_fetch  (halt_fetch),
        .sleeping    (sleeping)
    );

    typedef struct {
        logic        v;
        logic [63:0] pc;
        logic        pc_chk;
        logic        fl;
        logic        halt;
        logic        slp;
    } exp_t;

    typedef struct {
        logic        stall;
        logic        trap_en;
        logic [63:0] trap_pc;
        logic        bj_en;
        logic [63:0] bj_pc;
        logic        wfi_op;
        logic        exp_v;
        logic [63:0] exp_pc;
    } vec_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic exp_t mk(logic v, logic [63:0] p, logic fl, logic halt, logic slp);
        exp_t e;
        e.v = v; e.pc = p; e.pc_chk = v; e.fl = fl; e.halt = halt; e.slp = slp;
        return e;
    endfunction

    function automatic exp_t mk_zero();
        exp_t e;
        e = mk(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        e.pc_chk = 1'b1;
        return e;
    endfunction

    task automatic check_out();
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (redir_valid !== e.v || flush !== e.fl || halt_fetch !== e.halt ||
            sleeping !== e.slp || (e.pc_chk && redir_pc !== e.pc)) begin
            errors++;
            $display("FAIL %s: got v=%0b pc=%h fl=%0b halt=%0b slp=%0b, expected v=%0b pc=%h fl=%0b halt=%0b slp=%0b",
                     nm, redir_valid, redir_pc, flush, halt_fetch, sleeping,
                     e.v, e.pc, e.fl, e.halt, e.slp);
        end
    endtask

    task automatic cyc(input string nm, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic check_now(input string nm, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        check_out();
    endtask

    task automatic idle_inputs();
        stall = 0; bj_en = 0; trap_en = 0; wfi_op = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{0, 0, 64'h0,                   1, 64'h8000_0100,          0, 1, 64'h8000_0100};
        vecs[1] = '{0, 1, 64'h8000_0004,          1, 64'h200,                0, 1, 64'h8000_0004};
        vecs[2] = '{1, 0, 64'h0,                   1, 64'h1234,               0, 0, 64'h0};
        vecs[3] = '{0, 1, 64'hFFFF_FFFF_FFFF_FFF0, 0, 64'h0,                  0, 1, 64'hFFFF_FFFF_FFFF_FFF0};
        vecs[4] = '{1, 1, 64'h5555,                1, 64'h6666,               1, 0, 64'h0};
        vecs[5] = '{0, 0, 64'h0,                   1, 64'hDEAD_BEEF_0000_0000, 0, 1, 64'hDEAD_BEEF_0000_0000};
        vecs[6] = '{0, 1, 64'h0000_0000_0000_0100, 0, 64'h0,                  1, 1, 64'h100};
        vecs[7] = '{0, 0, 64'h0,                   1, 64'h0000_0000_0000_0008, 1, 1, 64'h8};

        rst_n = 0; stall = 0; pc = 0; bj_en = 0; bj_pc = 0; trap_en = 0; trap_pc = 0;
        wfi_op = 0; irq_pending = 0; fetch_ready = 1;
        #12;
        check_now("reset", mk_zero());
        @(posedge clk); #1;
        rst_n = 1;
        cyc("post_reset_idle", mk_zero());

        // Single-cycle events from idle, each followed by a completion cycle
        for (int i = 0; i < 8; i++) begin
            stall   = vecs[i].stall;
            trap_en = vecs[i].trap_en; trap_pc = vecs[i].trap_pc;
            bj_en   = vecs[i].bj_en;   bj_pc   = vecs[i].bj_pc;
            wfi_op  = vecs[i].wfi_op;  pc      = 64'h4444;
            fetch_ready = 1;
            cyc($sformatf("vec%0d", i), mk(vecs[i].exp_v, vecs[i].exp_pc, vecs[i].exp_v, 0, 0));
            idle_inputs();
            cyc($sformatf("vec%0d_done", i), mk(0, 0, 0, 0, 0));
        end

        // Held redirect ignores a trap, then back-to-back accept after completion
        bj_en = 1; bj_pc = 64'h4000; fetch_ready = 0;
        cyc("hold_c1", mk(1, 64'h4000, 1, 0, 0));
        bj_en = 0; trap_en = 1; trap_pc = 64'h9999;
        cyc("hold_c2", mk(1, 64'h4000, 1, 0, 0));
        cyc("hold_c3", mk(1, 64'h4000, 1, 0, 0));
        trap_en = 0; fetch_ready = 1;
        cyc("hold_done", mk(0, 0, 0, 0, 0));
        trap_en = 1;
        cyc("b2b_trap", mk(1, 64'h9999, 1, 0, 0));
        trap_en = 0;
        cyc("b2b_done", mk(0, 0, 0, 0, 0));

        // WFI blocked by stall, then taken; irq five cycles after acceptance
        stall = 1; wfi_op = 1; pc = 64'h1000; fetch_ready = 0;
        cyc("wfi_stalled", mk(0, 0, 0, 0, 0));
        stall = 0;
        cyc("wfi_enter", mk(0, 0, 1, 1, 1));
        wfi_op = 0; trap_en = 1; trap_pc = 64'h7777;
        cyc("sleep_trap_ign", mk(0, 0, 0, 1, 1));
        trap_en = 0;
        for (int i = 0; i < 3; i++) cyc($sformatf("sleep_%0d", i), mk(0, 0, 0, 1, 1));
        irq_pending = 1;
        cyc("wake", mk(0, 0, 0, 1, 0));
        bj_en = 1; bj_pc = 64'h6666;
        cyc("wake_redir", mk(1, 64'h1004, 1, 0, 0));
        bj_en = 0; irq_pending = 0; fetch_ready = 1;
        cyc("wake_done", mk(0, 0, 0, 0, 0));

        // irq already pending at entry: one SLEEP cycle, pc+4 wraps to zero
        irq_pending = 1; wfi_op = 1; pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc("fast_enter", mk(0, 0, 1, 1, 1));
        wfi_op = 0;
        cyc("fast_wake", mk(0, 0, 0, 1, 0));
        cyc("fast_redir", mk(1, 64'h0, 1, 0, 0));
        irq_pending = 0;
        cyc("fast_done", mk(0, 0, 0, 0, 0));

`ifdef WFI_TIMEOUT_EN
        wfi_op = 1; pc = 64'h3000;
        cyc("tmo_enter", mk(0, 0, 1, 1, 1));
        wfi_op = 0;
        for (int i = 0; i < 7; i++) cyc($sformatf("tmo_sleep_%0d", i), mk(0, 0, 0, 1, 1));
        cyc("tmo_wake", mk(0, 0, 0, 1, 0));
        cyc("tmo_redir", mk(1, 64'h3004, 1, 0, 0));
        cyc("tmo_done", mk(0, 0, 0, 0, 0));
`else
        wfi_op = 1; pc = 64'h3000;
        cyc("notmo_enter", mk(0, 0, 1, 1, 1));
        wfi_op = 0;
        for (int i = 0; i < 11; i++) cyc($sformatf("notmo_sleep_%0d", i), mk(0, 0, 0, 1, 1));
        irq_pending = 1;
        cyc("notmo_wake", mk(0, 0, 0, 1, 0));
        irq_pending = 0;
        cyc("notmo_redir", mk(1, 64'h3004, 1, 0, 0));
        cyc("notmo_done", mk(0, 0, 0, 0, 0));
`endif

        // Asynchronous reset in the middle of sleep and of a held redirect
        wfi_op = 1; pc = 64'h2000;
        cyc("rs_enter", mk(0, 0, 1, 1, 1));
        wfi_op = 0;
        cyc("rs_sleep0", mk(0, 0, 0, 1, 1));
        cyc("rs_sleep1", mk(0, 0, 0, 1, 1));
        #2 rst_n = 0;
        #1 check_now("rst_mid_sleep", mk_zero());
        @(posedge clk); #1;
        rst_n = 1;
        cyc("rst_idle", mk_zero());
        bj_en = 1; bj_pc = 64'h5000; fetch_ready = 0;
        cyc("rs_bj", mk(1, 64'h5000, 1, 0, 0));
        bj_en = 0;
        #2 rst_n = 0;
        #1 check_now("rst_mid_redir", mk_zero());
        @(posedge clk); #1;
        rst_n = 1; fetch_ready = 1;
        wfi_op = 1; pc = 64'h8000;
        cyc("post_rst_wfi", mk(0, 0, 1, 1, 1));
        wfi_op = 0; irq_pending = 1;
        cyc("post_rst_wake", mk(0, 0, 0, 1, 0));
        irq_pending = 0;
        cyc("post_rst_redir", mk(1, 64'h8004, 1, 0, 0));
        cyc("post_rst_done", mk(0, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
